// File: rtl/current_switch_sequencer_if.sv
// Request/status bundle between control logic and the current switch sequencer.
interface current_switch_sequencer_if #(
  parameter int N_ARRAY = 47,
  parameter int CODE_W  = 6
);
  logic [CODE_W-1:0]  code_in;
  logic               code_valid;
  logic               code_ready;
  logic               abort;
  logic [N_ARRAY-1:0] ctrl;
  logic [CODE_W-1:0]  cur_code;
  logic               busy;
  logic               done;
  logic               sat;

  modport master (
    output code_in, code_valid, abort,
    input  code_ready, ctrl, cur_code, busy, done, sat
  );

  modport slave (
    input  code_in, code_valid, abort,
    output code_ready, ctrl, cur_code, busy, done, sat
  );
endinterface

// File: rtl/current_switch_sequencer.sv
// Ramps a thermometer current switch array one cell per STEP_CYCLES toward a requested count.
// Optional macro CSS_DWA_EN selects data-weighted rotation of the on-cell window.
module current_switch_sequencer #(
  parameter int N_ARRAY     = 47,
  parameter int CODE_W      = 6,
  parameter int STEP_CYCLES = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  current_switch_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_SETTLE} state_t;

  localparam int                CNT_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CODE_W-1:0] FULL     = CODE_W'(N_ARRAY);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CODE_W-1:0]  r_target;
  logic [CODE_W-1:0]  r_cur;
  logic [N_ARRAY-1:0] r_ctrl;
  logic               r_busy;
  logic               r_done;
  logic               r_sat;

  logic [CODE_W-1:0]  w_ptr;
  logic [CODE_W-1:0]  w_req;
  logic               w_up;
  logic [CODE_W-1:0]  w_idx;
  logic [CODE_W-1:0]  w_next_cur;
  logic [N_ARRAY-1:0] w_mask;

  function automatic logic [CODE_W-1:0] sat_code(input logic [CODE_W-1:0] c);
    return (c > FULL) ? FULL : c;
  endfunction

  // Reduce a sum of two in-range cell indices back into 0..N_ARRAY-1.
  function automatic logic [CODE_W-1:0] wrap_idx(input logic [CODE_W:0] s);
    return (s >= (CODE_W+1)'(N_ARRAY)) ? CODE_W'(s - (CODE_W+1)'(N_ARRAY)) : CODE_W'(s);
  endfunction

`ifdef CSS_DWA_EN
  logic [CODE_W-1:0] r_ptr;
  assign w_ptr = r_ptr;
  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (r_state == S_RAMP && !bus.abort && r_cnt == CNT_LAST && !w_up)
      r_ptr <= wrap_idx({1'b0, r_ptr} + (CODE_W+1)'(1));
  end
  // Down steps retire the oldest cell of the circular window.
  assign w_idx = w_up ? wrap_idx({1'b0, w_ptr} + {1'b0, r_cur}) : w_ptr;
`else
  assign w_ptr = '0;
  assign w_idx = w_up ? wrap_idx({1'b0, w_ptr} + {1'b0, r_cur}) : (r_cur - CODE_W'(1));
`endif

  assign w_req      = sat_code(bus.code_in);
  assign w_up       = (r_target > r_cur);
  assign w_next_cur = w_up ? (r_cur + CODE_W'(1)) : (r_cur - CODE_W'(1));
  assign w_mask     = N_ARRAY'(1) << w_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_target <= '0;
      r_cur    <= '0;
      r_ctrl   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.code_valid) begin
            r_target <= w_req;
            r_sat    <= (bus.code_in > FULL);
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= (w_req != r_cur) ? S_RAMP : S_SETTLE;
          end
        end
        S_RAMP: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_cur  <= w_next_cur;
            r_ctrl <= w_up ? (r_ctrl | w_mask) : (r_ctrl & ~w_mask);
            if (w_next_cur == r_target)
              r_state <= S_SETTLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.code_ready = (r_state == S_IDLE) && !rst;
  assign bus.ctrl       = r_ctrl;
  assign bus.cur_code   = r_cur;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.sat        = r_sat;

endmodule
